iobuf_ctrl: RTL and testbench

IOBUF_CTRL -- requirements
Module: iobuf_ctrl

---
 rtl/iobuf_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_iobuf_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/iobuf_ctrl.sv
// Direction/turnaround controller for a 74LVC1T45 + 74LVC1G07 pin buffer pair.
// Sequences DIR and the FPGA output enable so the FPGA never drives into a buffer facing the FPGA.
module iobuf_ctrl #(
  parameter int GUARD_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode_valid,
  input  logic [1:0] mode,
  output logic       mode_ready,
  output logic [1:0] mode_cur,
  input  logic       dout_data,
  output logic       pin_in,
  output logic       pin_rise,
  output logic       pin_fall,
  output logic       bufdir,
  output logic       bufod,
  output logic       bufdat_tristate_oe,
  output logic       bufdat_tristate_dout,
  input  logic       bufdat_tristate_din
);

  typedef enum logic [2:0] {
    S_HIZ   = 3'd0,
    S_PP    = 3'd1,
    S_OD    = 3'd2,
    S_TO_PP = 3'd3,
    S_TO_IN = 3'd4
  } state_t;

  localparam logic [1:0] MODE_HIZ   = 2'b00;
  localparam logic [1:0] MODE_PP    = 2'b01;
  localparam logic [1:0] MODE_OD    = 2'b10;
  localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       target_od_reg, target_od_next;
  logic       dir_reg, dir_next;
  logic       od_reg, od_next;
  logic       oe_reg, oe_next;
  logic       dout_reg, dout_next;
  logic       ready_reg, ready_next;
  logic [1:0] cur_reg, cur_next;

  logic [1:0] sync_reg;
  logic       rise_reg, fall_reg;

  logic accept;
  logic req_pp;
  logic req_od;

  assign accept = mode_valid && ready_reg;
  assign req_pp = (mode == MODE_PP);
  assign req_od = (mode == MODE_OD);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    target_od_next = target_od_reg;
    dir_next       = dir_reg;
    od_next        = od_reg;
    oe_next        = oe_reg;
    dout_next      = dout_reg;
    ready_next     = ready_reg;
    cur_next       = cur_reg;

    case (state_reg)
      S_HIZ: begin
        if (accept) begin
          if (req_pp) begin
            state_next = S_TO_PP;
            dir_next   = 1'b1;
            od_next    = 1'b1;
            oe_next    = 1'b0;
            ready_next = 1'b0;
            cnt_next   = GUARD_LOAD;
          end else if (req_od) begin
            state_next = S_OD;
            od_next    = dout_data;
            cur_next   = MODE_OD;
          end
        end
      end

      S_OD: begin
        od_next = dout_data;
        if (accept) begin
          if (req_pp) begin
            // DIR flips first; OE waits for the guard interval in S_TO_PP
            state_next = S_TO_PP;
            dir_next   = 1'b1;
            od_next    = 1'b1;
            oe_next    = 1'b0;
            ready_next = 1'b0;
            cnt_next   = GUARD_LOAD;
          end else if (!req_od) begin
            state_next = S_HIZ;
            od_next    = 1'b1;
            cur_next   = MODE_HIZ;
          end
        end
      end

      S_PP: begin
        dout_next = dout_data;
        if (accept && !req_pp) begin
          // Release OE now, keep DIR toward the header until the guard expires
          state_next     = S_TO_IN;
          oe_next        = 1'b0;
          dir_next       = 1'b1;
          od_next        = 1'b1;
          ready_next     = 1'b0;
          target_od_next = req_od;
          cnt_next       = GUARD_LOAD;
        end
      end

      S_TO_PP: begin
        if (cnt_reg <= 4'd1) begin
          state_next = S_PP;
          oe_next    = 1'b1;
          dout_next  = dout_data;
          ready_next = 1'b1;
          cur_next   = MODE_PP;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      S_TO_IN: begin
        if (cnt_reg <= 4'd1) begin
          dir_next   = 1'b0;
          ready_next = 1'b1;
          cnt_next   = 4'd0;
          if (target_od_reg) begin
            state_next = S_OD;
            od_next    = dout_data;
            cur_next   = MODE_OD;
          end else begin
            state_next = S_HIZ;
            od_next    = 1'b1;
            cur_next   = MODE_HIZ;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      default: begin
        state_next = S_HIZ;
        dir_next   = 1'b0;
        od_next    = 1'b1;
        oe_next    = 1'b0;
        ready_next = 1'b1;
        cur_next   = MODE_HIZ;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_HIZ;
      cnt_reg       <= 4'd0;
      target_od_reg <= 1'b0;
      dir_reg       <= 1'b0;
      od_reg        <= 1'b1;
      oe_reg        <= 1'b0;
      dout_reg      <= 1'b0;
      ready_reg     <= 1'b1;
      cur_reg       <= MODE_HIZ;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      target_od_reg <= target_od_next;
      dir_reg       <= dir_next;
      od_reg        <= od_next;
      oe_reg        <= oe_next;
      dout_reg      <= dout_next;
      ready_reg     <= ready_next;
      cur_reg       <= cur_next;
    end
  end

  // Edge pulses are aligned with the pin_in update: sync_reg[0] is next pin_in, sync_reg[1] is current
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg <= 2'b00;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], bufdat_tristate_din};
      rise_reg <= sync_reg[0] & ~sync_reg[1];
      fall_reg <= ~sync_reg[0] & sync_reg[1];
    end
  end

  assign mode_ready           = ready_reg;
  assign mode_cur             = cur_reg;
  assign bufdir               = dir_reg;
  assign bufod                = od_reg;
  assign bufdat_tristate_oe   = oe_reg;
  assign bufdat_tristate_dout = dout_reg;
  assign pin_in               = sync_reg[1];
  assign pin_rise             = rise_reg;
  assign pin_fall             = fall_reg;

endmodule

// File: tb/tb_iobuf_ctrl.sv
// Scoreboard bench for iobuf_ctrl: directed stimulus pushes cycle-stamped expectations,
// a negedge monitor pops and compares them and checks the OE/DIR invariant every cycle.
module tb_iobuf_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode_valid = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       dout_data = 1'b0;
  logic       din = 1'b0;

  logic       mode_ready;
  logic [1:0] mode_cur;
  logic       pin_in, pin_rise, pin_fall;
  logic       bufdir, bufod, bufdat_tristate_oe, bufdat_tristate_dout;

  iobuf_ctrl #(.GUARD_CYCLES(2)) dut (
    .clock                (clock),
    .reset                (reset),
    .mode_valid           (mode_valid),
    .mode                 (mode),
    .mode_ready           (mode_ready),
    .mode_cur             (mode_cur),
    .dout_data            (dout_data),
    .pin_in               (pin_in),
    .pin_rise             (pin_rise),
    .pin_fall             (pin_fall),
    .bufdir               (bufdir),
    .bufod                (bufod),
    .bufdat_tristate_oe   (bufdat_tristate_oe),
    .bufdat_tristate_dout (bufdat_tristate_dout),
    .bufdat_tristate_din  (din)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // {ready, cur[1:0], dir, od, oe, dout, pin_in, rise, fall}
  logic [9:0] obs;
  assign obs = {mode_ready, mode_cur, bufdir, bufod, bufdat_tristate_oe,
                bufdat_tristate_dout, pin_in, pin_rise, pin_fall};

  localparam logic [9:0] M_CTL  = 10'b1111110000;
  localparam logic [9:0] M_DOUT = 10'b0000001000;
  localparam logic [9:0] M_PIN  = 10'b0000000111;
  localparam logic [9:0] M_ALL  = 10'b1111111111;

  typedef struct {
    int         cyc;
    logic [9:0] val;
    logic [9:0] msk;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    rise_cnt = 0;
  int    fall_cnt = 0;

  function automatic logic [9:0] ctl(input logic rdy, input logic [1:0] cur,
                                     input logic dir, input logic od, input logic oe);
    return {rdy, cur, dir, od, oe, 4'b0000};
  endfunction

  task automatic expect_at(input int off, input string nm, input logic [9:0] v, input logic [9:0] m);
    exp_t e;
    e.cyc = cyc + off;
    e.val = v;
    e.msk = m;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  exp_t  mon_e;
  string mon_nm;

  always @(negedge clock) begin
    checks++;
    if (bufdat_tristate_oe === 1'b1 && bufdir !== 1'b1) begin
      errors++;
      $display("FAIL oe_dir_invariant cyc=%0d oe=%b dir=%b required no oe=1 with dir=0",
               cyc, bufdat_tristate_oe, bufdir);
    end
    if (pin_rise === 1'b1) rise_cnt++;
    if (pin_fall === 1'b1) fall_cnt++;
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      checks++;
      if (mon_e.cyc < cyc) begin
        errors++;
        $display("FAIL %s missed cyc=%0d expected at cyc=%0d", mon_nm, cyc, mon_e.cyc);
      end else if ((obs & mon_e.msk) !== (mon_e.val & mon_e.msk)) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%b required=%b mask=%b",
                 mon_nm, cyc, obs, mon_e.val, mon_e.msk);
      end else begin
        $display("ok   %s cyc=%0d obs=%b", mon_nm, cyc, obs);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    // Reset wins over a simultaneous request
    reset = 1'b1; mode_valid = 1'b1; mode = 2'b01; dout_data = 1'b1;
    tick(2);
    expect_at(1, "reset_prio", 10'b1000100000, M_ALL);
    tick(1);
    reset = 1'b0; mode_valid = 1'b0; mode = 2'b00; dout_data = 1'b0;
    expect_at(1, "reset_idle", 10'b1000100000, M_ALL);
    tick(1);

    // HIZ -> PP with guard of 2
    mode_valid = 1'b1; mode = 2'b01;
    expect_at(1, "to_pp_e0", ctl(1'b0, 2'b00, 1'b1, 1'b1, 1'b0), M_CTL);
    expect_at(2, "to_pp_e1", ctl(1'b0, 2'b00, 1'b1, 1'b1, 1'b0), M_CTL);
    expect_at(3, "to_pp_e2", ctl(1'b1, 2'b01, 1'b1, 1'b1, 1'b1), M_CTL);
    tick(1);
    mode_valid = 1'b0;
    tick(2);
    dout_data = 1'b1;
    expect_at(1, "pp_dout_hi", 10'b0000001000, M_DOUT);
    tick(1);
    dout_data = 1'b0;
    expect_at(1, "pp_dout_lo", 10'b0000000000, M_DOUT);
    tick(1);
    mode_valid = 1'b1; mode = 2'b01;
    expect_at(1, "pp_same", ctl(1'b1, 2'b01, 1'b1, 1'b1, 1'b1), M_CTL);
    tick(1);
    mode_valid = 1'b0;
    expect_at(1, "pp_same_hold", ctl(1'b1, 2'b01, 1'b1, 1'b1, 1'b1), M_CTL);
    tick(1);

    // PP -> OD with dout_data = 0
    mode_valid = 1'b1; mode = 2'b10;
    expect_at(1, "to_od_e0", ctl(1'b0, 2'b01, 1'b1, 1'b1, 1'b0), M_CTL);
    expect_at(2, "to_od_e1", ctl(1'b0, 2'b01, 1'b1, 1'b1, 1'b0), M_CTL);
    expect_at(3, "to_od_e2", ctl(1'b1, 2'b10, 1'b0, 1'b0, 1'b0), M_CTL);
    tick(1);
    mode_valid = 1'b0;
    tick(2);
    dout_data = 1'b1;
    expect_at(1, "od_hi", ctl(1'b1, 2'b10, 1'b0, 1'b1, 1'b0), M_CTL);
    tick(1);
    dout_data = 1'b0;
    expect_at(1, "od_lo", ctl(1'b1, 2'b10, 1'b0, 1'b0, 1'b0), M_CTL);
    tick(1);

    // Back-to-back OD/HIZ switches, including reserved mode 11
    mode_valid = 1'b1; mode = 2'b00;
    expect_at(1, "od_to_hiz", ctl(1'b1, 2'b00, 1'b0, 1'b1, 1'b0), M_CTL);
    tick(1);
    mode = 2'b10;
    expect_at(1, "hiz_to_od", ctl(1'b1, 2'b10, 1'b0, 1'b0, 1'b0), M_CTL);
    tick(1);
    mode = 2'b11;
    expect_at(1, "od_to_rsvd", ctl(1'b1, 2'b00, 1'b0, 1'b1, 1'b0), M_CTL);
    tick(1);
    mode_valid = 1'b0;
    tick(1);

    // Request held during S_TO_PP is ignored, then accepted once settled
    mode_valid = 1'b1; mode = 2'b01;
    expect_at(1, "busy_e0", ctl(1'b0, 2'b00, 1'b1, 1'b1, 1'b0), M_CTL);
    tick(1);
    mode = 2'b00;
    expect_at(1, "busy_ignored", ctl(1'b0, 2'b00, 1'b1, 1'b1, 1'b0), M_CTL);
    expect_at(2, "busy_settle_pp", ctl(1'b1, 2'b01, 1'b1, 1'b1, 1'b1), M_CTL);
    expect_at(3, "retry_accept", ctl(1'b0, 2'b01, 1'b1, 1'b1, 1'b0), M_CTL);
    expect_at(4, "retry_to_in_e1", ctl(1'b0, 2'b01, 1'b1, 1'b1, 1'b0), M_CTL);
    expect_at(5, "retry_hiz", ctl(1'b1, 2'b00, 1'b0, 1'b1, 1'b0), M_CTL);
    tick(3);
    mode_valid = 1'b0;
    tick(2);

    // Reset in the middle of S_TO_IN
    mode_valid = 1'b1; mode = 2'b01;
    expect_at(3, "pp_again", ctl(1'b1, 2'b01, 1'b1, 1'b1, 1'b1), M_CTL);
    tick(1);
    mode_valid = 1'b0;
    tick(2);
    mode_valid = 1'b1; mode = 2'b00;
    expect_at(1, "to_in_e0", ctl(1'b0, 2'b01, 1'b1, 1'b1, 1'b0), M_CTL);
    tick(1);
    mode_valid = 1'b0; reset = 1'b1;
    expect_at(1, "abort_reset", 10'b1000100000, M_ALL);
    tick(1);
    reset = 1'b0;
    expect_at(2, "post_abort", ctl(1'b1, 2'b00, 1'b0, 1'b1, 1'b0), M_CTL);
    tick(3);

    // Pin synchronizer and edge pulses
    din = 1'b1;
    expect_at(1, "din_hi_lat1", 10'b0000000000, M_PIN);
    expect_at(2, "pin_rise", 10'b0000000110, M_PIN);
    expect_at(3, "rise_end", 10'b0000000100, M_PIN);
    tick(5);
    din = 1'b0;
    expect_at(1, "din_lo_lat1", 10'b0000000100, M_PIN);
    expect_at(2, "pin_fall", 10'b0000000001, M_PIN);
    expect_at(3, "fall_end", 10'b0000000000, M_PIN);
    tick(5);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    checks++;
    if (rise_cnt != 1) begin
      errors++;
      $display("FAIL rise_count got=%0d required 1", rise_cnt);
    end
    checks++;
    if (fall_cnt != 1) begin
      errors++;
      $display("FAIL fall_count got=%0d required 1", fall_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
